nanov_sequencer: RTL and testbench

- Instruction-fetch and execution sequencer for the bit-serial nanoV core.
- Streams 32-bit instructions from an SPI flash (read command 0x03), holds the current instruction and PC, and drives the core's `instr`, `cycle`, `counter` and serial `pc` inputs.
- On a core `branch` it ends the flash transaction and restarts reading at the branch target; otherwise it keeps one continuous sequential read open.

---
 rtl/nanov_pkg.sv | 42 ++++
 rtl/nanov_sequencer_if.sv | 48 ++++
 rtl/nanov_spi_shift.sv | 30 +++
 rtl/nanov_sequencer.sv | 174 +++++++++++++++++
 tb/tb_nanov_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/nanov_pkg.sv
// Shared types and constants for the nanoV instruction sequencer.
// The NANOV_ILLEGAL_TRAP_EN build also uses the opcode and cycle-count helpers.
package nanov_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        FETCH = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    localparam logic [4:0]  OP_IMM           = 5'b00100;
    localparam logic [4:0]  OP               = 5'b01100;
    localparam logic [4:0]  JAL              = 5'b11011;
    localparam logic [7:0]  CMD_READ_DEFAULT = 8'h03;
    localparam logic [31:0] NOP              = 32'h00000013;

    // The first byte received sits in raw[31:24]; the flash stores words little-endian.
    function automatic logic [31:0] flash_to_word(input logic [31:0] raw);
        return {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
    endfunction

    function automatic logic opcode_legal(input logic [6:0] opc);
        logic ok;
        ok = (opc[1:0] == 2'b11) &&
             ((opc[6:2] == OP_IMM) || (opc[6:2] == OP) || (opc[6:2] == JAL));
        return ok;
    endfunction

    // JAL and shifts need a second bit-serial pass; everything else is single-cycle.
    function automatic logic [2:0] decode_ncyc(input logic [31:0] ins);
        logic [2:0] n;
        n = 3'd1;
        if (ins[6:4] == 3'b110 && ins[2])
            n = 3'd2;
        if (ins[4:0] == 5'b10011 && ins[13:12] == 2'b01)
            n = 3'd2;
        return n;
    endfunction

endpackage

// File: rtl/nanov_sequencer_if.sv
// Flash SPI pins plus the core-facing execution bus of the nanoV sequencer.
// master = sequencer side, slave = flash/core side.
interface nanov_sequencer_if;

    logic        spi_miso;
    logic        spi_mosi;
    logic        spi_select;
    logic        spi_sck_en;
    logic [31:0] instr;
    logic [2:0]  cycle;
    logic [4:0]  counter;
    logic        pc;
    logic        branch;
    logic [31:0] branch_target;
    logic        exec_valid;
    logic        illegal;

    modport master (
        input  spi_miso,
        input  branch,
        input  branch_target,
        output spi_mosi,
        output spi_select,
        output spi_sck_en,
        output instr,
        output cycle,
        output counter,
        output pc,
        output exec_valid,
        output illegal
    );

    modport slave (
        output spi_miso,
        output branch,
        output branch_target,
        input  spi_mosi,
        input  spi_select,
        input  spi_sck_en,
        input  instr,
        input  cycle,
        input  counter,
        input  pc,
        input  exec_valid,
        input  illegal
    );

endinterface

// File: rtl/nanov_spi_shift.sv
// 32-bit shift register shared by the command phase (MSB out on q[31]) and the
// data phase (miso in at q[0]), with a 0..31 bit counter.
module nanov_spi_shift (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        shift_en,
    input  logic        din,
    output logic [31:0] q,
    output logic [4:0]  bit_cnt,
    output logic        last
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q       <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            q       <= load_val;
            bit_cnt <= '0;
        end else if (shift_en) begin
            q       <= {q[30:0], din};
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    assign last = (bit_cnt == 5'd31);

endmodule

// File: rtl/nanov_sequencer.sv
// Fetch/execute sequencer for the bit-serial nanoV core, streaming from SPI flash.
// Optional NANOV_ILLEGAL_TRAP_EN: multi-cycle decode plus sticky illegal-opcode HALT.
//
// state | meaning
// IDLE  | select high for one clk between transactions
// CMD   | shifting read opcode + 24-bit address out on mosi
// FETCH | shifting 32 instruction bits in from miso
// EXEC  | core executing instr, counter/cycle running, flash paused
// HALT  | illegal opcode trapped; only rstn leaves
module nanov_sequencer
    import nanov_pkg::*;
#(
    parameter logic [23:0] RESET_ADDR = 24'h000000,
    parameter logic [7:0]  CMD_READ   = CMD_READ_DEFAULT
) (
    input logic               clk,
    input logic               rstn,
    nanov_sequencer_if.master bus
);

    seq_state_t  state;
    seq_state_t  state_nxt;

    logic [31:0] pc_reg;
    logic [31:0] instr_q;
    logic [2:0]  cycle_q;
    logic [4:0]  counter_q;
    logic        branch_pend;

    logic        sh_load;
    logic        sh_shift;
    logic [31:0] sh_q;
    logic [4:0]  bit_cnt;
    logic        sh_last;

    logic [31:0] fetch_word;
    logic [2:0]  ncyc;
    logic        final_clk;
    logic        taken;
    logic [31:0] next_pc;
    logic        fetch_done;

    logic        select_c;
    logic        sck_en_c;
    logic        exec_c;

    nanov_spi_shift u_shift (
        .clk      (clk),
        .rstn     (rstn),
        .load     (sh_load),
        .load_val ({CMD_READ, pc_reg[23:0]}),
        .shift_en (sh_shift),
        .din      (bus.spi_miso),
        .q        (sh_q),
        .bit_cnt  (bit_cnt),
        .last     (sh_last)
    );

    // Include the bit arriving this clk so instr is valid on the last FETCH edge.
    assign fetch_word = flash_to_word({sh_q[30:0], bus.spi_miso});
    assign fetch_done = (state == FETCH) && sh_last;

`ifdef NANOV_ILLEGAL_TRAP_EN
    logic fetch_bad;
    logic illegal_q;

    assign ncyc      = decode_ncyc(instr_q);
    assign fetch_bad = !opcode_legal(fetch_word[6:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            illegal_q <= 1'b0;
        else if (fetch_done && fetch_bad)
            illegal_q <= 1'b1;
    end

    assign bus.illegal = illegal_q;
`else
    assign ncyc        = 3'd1;
    assign bus.illegal = 1'b0;
`endif

    assign final_clk = (state == EXEC) && (counter_q == 5'd31) && (cycle_q == ncyc - 3'd1);
    assign taken     = branch_pend | bus.branch;
    assign next_pc   = taken ? bus.branch_target : pc_reg + 32'd4;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = CMD;
            CMD:   if (sh_last) state_nxt = FETCH;
            FETCH: begin
                if (sh_last) begin
`ifdef NANOV_ILLEGAL_TRAP_EN
                    state_nxt = fetch_bad ? HALT : EXEC;
`else
                    state_nxt = EXEC;
`endif
                end
            end
            // A taken branch needs a fresh read command; otherwise the flash keeps streaming.
            EXEC:  if (final_clk) state_nxt = taken ? IDLE : FETCH;
`ifdef NANOV_ILLEGAL_TRAP_EN
            HALT:  state_nxt = HALT;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        select_c = 1'b1;
        sck_en_c = 1'b0;
        exec_c   = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        unique case (state)
            IDLE: sh_load = 1'b1;
            CMD, FETCH: begin
                select_c = 1'b0;
                sck_en_c = 1'b1;
                sh_shift = 1'b1;
            end
            EXEC: begin
                select_c = 1'b0;
                exec_c   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_reg      <= {8'h00, RESET_ADDR};
            instr_q     <= NOP;
            cycle_q     <= '0;
            counter_q   <= '0;
            branch_pend <= 1'b0;
        end else begin
            if (fetch_done) begin
                instr_q   <= fetch_word;
                counter_q <= '0;
                cycle_q   <= '0;
            end
            if (state == EXEC) begin
                counter_q <= counter_q + 5'd1;
                if (counter_q == 5'd31)
                    cycle_q <= cycle_q + 3'd1;
                if (final_clk) begin
                    pc_reg      <= next_pc;
                    branch_pend <= 1'b0;
                end else if (bus.branch) begin
                    branch_pend <= 1'b1;
                end
            end
        end
    end

    assign bus.spi_select = select_c;
    assign bus.spi_sck_en = sck_en_c;
    assign bus.spi_mosi   = sh_q[31];
    assign bus.exec_valid = exec_c;
    assign bus.instr      = instr_q;
    assign bus.cycle      = cycle_q;
    assign bus.counter    = counter_q;
    assign bus.pc         = exec_c & pc_reg[counter_q];

endmodule

// File: tb/tb_nanov_sequencer.sv
// Bench for nanov_sequencer: behavioural SPI flash plus an instruction-level model
// of fetch address, execution length, gap timing and the serial PC.
module tb_nanov_sequencer;

`ifdef NANOV_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    nanov_sequencer_if bus ();

    nanov_sequencer #(
        .RESET_ADDR (24'h000000),
        .CMD_READ   (8'h03)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int cyc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] model_pc;
    int          exp_start, exp_sel, sel_cnt;
    bit          in_exec;
    int          k, len, bk, n_done;
    bit          taken, force_illegal;
    logic [31:0] target, pc_acc, cur;
    int          fl_cnt;
    logic [31:0] fl_cmd;
    logic [23:0] fl_addr;
    int          ev_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Flash contents: a few directed words, otherwise hashed legal instructions.
    function automatic logic [31:0] word_at(input logic [23:0] a);
        logic [31:0] h;
        case (a)
            24'h000000: return 32'h00100513;
            24'h000004: return 32'h00151513;
            24'h000008: return 32'h0000006F;
            24'h800000: return 32'hFFFFFFFF;
            default: ;
        endcase
        h = ({8'h00, a} * 32'h9E3779B1) ^ 32'h5BD1E995;
        case (h[9:8])
            2'd0:    return {h[31:7], 7'h13};
            2'd1:    return {h[31:7], 7'h33};
            2'd2:    return {h[31:7], 7'h6F};
            default: return {h[31:14], 2'b01, h[11:7], 7'h13};
        endcase
    endfunction

    function automatic logic flash_bit(input logic [23:0] base, input int n);
        logic [23:0] b;
        logic [31:0] w;
        logic [7:0]  by;
        b  = base + 24'(n / 8);
        w  = word_at({b[23:2], 2'b00});
        by = 8'(w >> (8 * b[1:0]));
        return by[7 - (n % 8)];
    endfunction

    function automatic int ncyc_of(input logic [31:0] w);
        bit jal, shf;
        jal = (w[6:4] == 3'b110) && w[2];
        shf = (w[4:0] == 5'b10011) && (w[13:12] == 2'b01);
        return (TRAP && (jal || shf)) ? 2 : 1;
    endfunction

    task automatic start_instr();
        in_exec = 1'b1;
        k = 0;
        chk("start_clk", 32'(cyc), 32'(exp_start));
        chk("sel_high_clks", 32'(sel_cnt), 32'(exp_sel));
        cur = word_at(model_pc[23:0]);
        chk("instr", bus.instr, cur);
        len    = 32 * ncyc_of(cur);
        bk     = int'($urandom_range(0, len - 1));
        target = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
        taken  = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) == 0) bk = len - 1;
        case (n_done)
            0, 1: taken = 1'b0;
            2: begin taken = 1'b1; target = 32'h00000100; bk = 5; end
            3: begin taken = 1'b1; target = 32'hFFFFFFFC; bk = len - 1; end
            4: taken = 1'b0;
            default: if (force_illegal) begin taken = 1'b1; target = 32'h00800000; end
        endcase
        bus.branch_target = taken ? target : $urandom();
    endtask

    task automatic end_instr();
        in_exec = 1'b0;
        chk("exec_len", 32'(k), 32'(len));
        chk("serial_pc", pc_acc, model_pc);
        model_pc  = taken ? target : model_pc + 32'd4;
        exp_start = cyc + (taken ? 65 : 32);
        exp_sel   = taken ? 1 : 0;
        sel_cnt   = 0;
        n_done++;
    endtask

    task automatic step();
        @(negedge clk);
        if (!rstn) return;
        bus.branch = 1'b0;
        if (bus.exec_valid) begin
            ev_cnt++;
            if (!in_exec) start_instr();
            chk("counter", 32'(bus.counter), 32'(k % 32));
            chk("cycle", 32'(bus.cycle), 32'(k / 32));
            if (k < 32) pc_acc[k] = bus.pc;
            bus.branch = taken && (k == bk);
            k++;
        end else begin
            if (in_exec) end_instr();
            bus.branch = ($urandom_range(0, 3) == 0);
        end
        if (bus.spi_select) begin
            fl_cnt = 0;
            sel_cnt++;
        end else if (bus.spi_sck_en) begin
            if (fl_cnt < 32) begin
                fl_cmd = {fl_cmd[30:0], bus.spi_mosi};
                if (fl_cnt == 31) begin
                    chk("read_cmd", fl_cmd, {8'h03, model_pc[23:0]});
                    fl_addr = fl_cmd[23:0];
                end
            end else begin
                bus.spi_miso = flash_bit(fl_addr, fl_cnt - 32);
            end
            fl_cnt++;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.branch = 1'b0;
        #1;
        chk("rst_select", 32'(bus.spi_select), 32'd1);
        chk("rst_sck_en", 32'(bus.spi_sck_en), 32'd0);
        chk("rst_mosi", 32'(bus.spi_mosi), 32'd0);
        chk("rst_instr", bus.instr, 32'h00000013);
        chk("rst_cycle", 32'(bus.cycle), 32'd0);
        chk("rst_counter", 32'(bus.counter), 32'd0);
        chk("rst_exec_valid", 32'(bus.exec_valid), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        model_pc  = 32'h0;
        exp_start = 65;
        exp_sel   = 1;
        sel_cnt   = 0;
        in_exec   = 1'b0;
        fl_cnt    = 0;
        n_done    = 0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic run_instrs(input int n);
        int goal, budget;
        goal   = n_done + n;
        budget = 0;
        while (n_done < goal && budget < n * 200) begin
            step();
            budget++;
        end
        chk("instr_progress", 32'(n_done), 32'(goal));
    endtask

    initial begin
        int budget;
        bus.spi_miso      = 1'b0;
        bus.branch        = 1'b0;
        bus.branch_target = 32'h0;
        force_illegal     = 1'b0;
        ev_cnt            = 0;
        #2;
        do_reset();
        run_instrs(40);

        // Reset in the middle of a data phase, with a real instruction held.
        budget = 0;
        while (!(!bus.spi_select && bus.spi_sck_en && fl_cnt >= 32 &&
                 ((fl_cnt - 32) % 32) == 17) && budget < 400) begin
            step();
            budget++;
        end
        chk("mid_fetch_reached", 32'(bus.spi_sck_en & ~bus.spi_select), 32'd1);
        do_reset();
        run_instrs(25);

`ifdef NANOV_ILLEGAL_TRAP_EN
        chk("illegal_before", 32'(bus.illegal), 32'd0);
        force_illegal = 1'b1;
        run_instrs(1);
        ev_cnt = 0;
        repeat (120) step();
        chk("illegal_sticky", 32'(bus.illegal), 32'd1);
        chk("halt_exec_clks", 32'(ev_cnt), 32'd0);
        chk("halt_select", 32'(bus.spi_select), 32'd1);
        chk("halt_sel_clks", 32'(sel_cnt), 32'd57);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
